// File: rtl/riscv_pipe_pkg.sv
//------------------------------------------------------------------------------
// riscv_pipe_pkg -- stage payload structs, their widths and control-field sizes. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pipe_pkg;

  localparam int ALU_OP_W = 5;
  localparam int BJ_W     = 3;
  localparam int RW_W     = 4;
  localparam int WB_SEL_W = 2;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          pc_plus4;
    logic [31:0]          rs1_data;
    logic [31:0]          rs2_data;
    logic [31:0]          imm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [BJ_W-1:0]      bj_sel;
    logic [RW_W-1:0]      rw_sel;
    logic [WB_SEL_W-1:0]  wb_sel;
    logic                 reg_write;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic                 mem_read;
    logic                 mem_write;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 is_branch;
  } id_ex_t;

  typedef struct packed {
    logic [31:0]          alu_result;
    logic [31:0]          rs2_data;
    logic [31:0]          pc_plus4;
    logic [4:0]           rd;
    logic [RW_W-1:0]      rw_sel;
    logic [WB_SEL_W-1:0]  wb_sel;
    logic                 reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0]          alu_result;
    logic [31:0]          mem_data;
    logic [31:0]          pc_plus4;
    logic [4:0]           rd;
    logic [WB_SEL_W-1:0]  wb_sel;
    logic                 reg_write;
  } mem_wb_t;

  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// pipe_stage_reg -- valid/ready pipeline register with stall, flush, optional skid. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W    = ID_EX_W,
  parameter bit SKID      = 1'b1,
  parameter bit FLUSH_CLR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_main_valid_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_deliver;

  assign w_out_valid = r_main_valid & ~stall & ~flush;

  // With the skid entry, ready depends only on flops, cutting the out_ready -> in_ready path.
  generate
    if (SKID) begin : g_skid_ready
      assign w_in_ready = ~r_skid_valid & ~stall & ~flush & ~reset;
    end else begin : g_comb_ready
      assign w_in_ready = (~r_main_valid | out_ready) & ~stall & ~flush & ~reset;
    end
  endgenerate

  assign w_accept  = in_valid & w_in_ready;
  assign w_deliver = w_out_valid & out_ready;

  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
      if (FLUSH_CLR) begin
        w_main_data_nxt = '0;
        w_skid_data_nxt = '0;
      end
    end else if (!stall) begin
      if (SKID) begin
        if (r_skid_valid) begin
          if (w_deliver) begin
            w_main_data_nxt  = r_skid_data;
            w_skid_valid_nxt = 1'b0;
          end
        end else if (r_main_valid) begin
          if (w_deliver && w_accept) begin
            w_main_data_nxt = in_data;
          end else if (w_deliver) begin
            w_main_valid_nxt = 1'b0;
          end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = in_data;
          end
        end else if (w_accept) begin
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = in_data;
        end
      end else begin
        if (w_accept) begin
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = in_data;
        end else if (w_deliver) begin
          w_main_valid_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire
